// File: rtl/apb_arbiter_master.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// pready wait with optional timeout, per-requester read data and error status.
module apb_arbiter_master #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic       pclk,
    input  logic       preset,

    input  logic       req0_valid,
    input  logic       req0_write,
    input  logic [7:0] req0_addr,
    input  logic [7:0] req0_wdata,
    output logic       req0_ack,
    output logic       req0_done,
    output logic [7:0] req0_rdata,
    output logic       req0_err,

    input  logic       req1_valid,
    input  logic       req1_write,
    input  logic [7:0] req1_addr,
    input  logic [7:0] req1_wdata,
    output logic       req1_ack,
    output logic       req1_done,
    output logic [7:0] req1_rdata,
    output logic       req1_err,

    output logic       psel,
    output logic       penable,
    output logic       pwrite,
    output logic [7:0] paddr,
    output logic [7:0] pwdata,
    input  logic [7:0] prdata,
    input  logic       pready,
    input  logic       pslverr
);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam bit               TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t           state;
    logic             owner;      // requester that owns the current transfer
    logic             last_id;    // requester granted most recently
    logic [CNT_W-1:0] cnt;

    logic       grant_valid_c;
    logic       grant_id_c;
    logic       sel_write_c;
    logic [7:0] sel_addr_c;
    logic [7:0] sel_wdata_c;
    logic       timeout_hit_c;
    logic       fin_c;
    logic       fin_err_c;
    logic       fin_load_c;
    logic [7:0] fin_rdata_c;

    // Round-robin grant: a lone requester wins, otherwise the one not granted last.
    always_comb begin
        grant_valid_c = req0_valid | req1_valid;
        grant_id_c    = req1_valid & (~req0_valid | ~last_id);
        sel_write_c   = grant_id_c ? req1_write : req0_write;
        sel_addr_c    = grant_id_c ? req1_addr  : req0_addr;
        sel_wdata_c   = grant_id_c ? req1_wdata : req0_wdata;
    end

    // Completion decode for the ACCESS phase: slave response or timeout abort.
    always_comb begin
        timeout_hit_c = TIMEOUT_EN && (cnt == CNT_LAST);
        fin_c         = 1'b0;
        fin_err_c     = 1'b0;
        fin_load_c    = 1'b0;
        fin_rdata_c   = 8'h00;
        if (state == ACCESS) begin
            if (pready) begin
                fin_c       = 1'b1;
                fin_err_c   = pslverr;
                fin_load_c  = ~pwrite;
                fin_rdata_c = prdata;
            end else if (timeout_hit_c) begin
                fin_c       = 1'b1;
                fin_err_c   = 1'b1;
                fin_load_c  = 1'b1;
                fin_rdata_c = 8'h00;
            end
        end
    end

    // Transfer FSM with registered bus and requester outputs.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_id    <= 1'b1;
            cnt        <= '0;
            req0_ack   <= 1'b0;
            req0_done  <= 1'b0;
            req0_rdata <= 8'h00;
            req0_err   <= 1'b0;
            req1_ack   <= 1'b0;
            req1_done  <= 1'b0;
            req1_rdata <= 8'h00;
            req1_err   <= 1'b0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= 8'h00;
            pwdata     <= 8'h00;
        end else begin
            req0_ack  <= 1'b0;
            req1_ack  <= 1'b0;
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid_c) begin
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        pwrite  <= sel_write_c;
                        paddr   <= sel_addr_c;
                        pwdata  <= sel_write_c ? sel_wdata_c : 8'h00;
                        owner   <= grant_id_c;
                        last_id <= grant_id_c;
                        if (grant_id_c) begin
                            req1_ack <= 1'b1;
                        end else begin
                            req0_ack <= 1'b1;
                        end
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    cnt     <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (fin_c) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        state   <= IDLE;
                        if (owner) begin
                            req1_done <= 1'b1;
                            req1_err  <= fin_err_c;
                            if (fin_load_c) begin
                                req1_rdata <= fin_rdata_c;
                            end
                        end else begin
                            req0_done <= 1'b1;
                            req0_err  <= fin_err_c;
                            if (fin_load_c) begin
                                req0_rdata <= fin_rdata_c;
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
